parc_core_fetch_queue: RTL and testbench
========================================

# parc_core_fetch_queue

Instruction fetch front end for the 5-stage PARCv2 core. It sits between the P/F stages and the Decode stage. It owns the fetch PC, issues instruction-memory requests, and tracks in-flight requests with an epoch tag so responses to squashed requests are discarded. Surviving responses are buffered and presented to D with a val/rdy handshake, so D no longer depends on fixed-latency instruction memory.

## Interface

Parameters:
- DEPTH, 2: number of buffer entries and maximum outstanding requests; power of two, at least 2.
- RESET_VECTOR, 32'h00080000: first fetch address after reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pc_redirect_val  in  1  redirect from the P-stage pc mux (branch/jump/jr taken).
- pc_redirect_addr  in  32  redirect target.
- imemreq_val  out  1  request valid.
- imemreq_rdy  in  1  memory can accept a request.
- imemreq_msg_addr  out  32  fetch address.
- imemresp_val  in  1  response valid; always accepted.
- imemresp_msg_data  in  32  instruction word.
- inst_val_Dhl  out  1  buffer head valid.
- inst_rdy_Dhl  in  1  D accepts the head (driven as !stall_Dhl).
- inst_Dhl  out  32  head instruction.
- pc_Dhl  out  32  head PC.
- pc_plus4_Dhl  out  32  head PC + 4.

## Operation

- State: pc_Fhl (32 bits); epoch bit; in-flight FIFO of DEPTH entries {addr, epoch}; instruction buffer of DEPTH entries {inst, pc}; one occupancy counter per FIFO, each log2(DEPTH)+1 bits.
- Fetch address: imemreq_msg_addr = pc_redirect_val ? pc_redirect_addr : pc_Fhl. The request carries the epoch value that is current after any redirect in this cycle.
- Credit check:
  - deq = inst_val_Dhl & inst_rdy_Dhl.
  - imemreq_val = (inflight_cnt + buf_cnt − deq) < DEPTH.
  - If pc_redirect_val is asserted, buf_cnt is taken as 0 in this check.
- Request fire (imemreq_val & imemreq_rdy):
  - push {imemreq_msg_addr, new epoch} into the in-flight FIFO;
  - pc_Fhl ← imemreq_msg_addr + 4 (32-bit wrap).
- Redirect without a fire: pc_Fhl ← pc_redirect_addr.
- Redirect effects:
  - epoch toggles;
  - the instruction buffer is flushed (buf_cnt ← 0, pointers reset);
  - a dequeue in the same cycle is still considered consumed.
- Response handling:
  - Every response pops the in-flight FIFO head.
  - If head.epoch == current epoch (after any same-cycle toggle), push {imemresp_msg_data, head.addr} into the buffer.
  - Otherwise the response is dropped silently.
  - A response arriving with inflight_cnt == 0 is ignored; this covers stale returns after reset.
- Output: inst_val_Dhl = buf_cnt != 0. inst_Dhl, pc_Dhl and pc_plus4_Dhl come from the buffer head and are 0 when the buffer is empty.
- Memory contract: responses return in order, no earlier than the cycle after the request.
- Overflow cannot occur, because credits bound inflight_cnt + buf_cnt to at most DEPTH.
- Simultaneous push and pop on a full buffer is legal; the count is unchanged.

## Timing

- During reset:
  - imemreq_val = 0, inst_val_Dhl = 0;
  - imemreq_msg_addr = RESET_VECTOR, pc_Fhl = RESET_VECTOR;
  - epoch = 0, both counters = 0;
  - inst_Dhl, pc_Dhl and pc_plus4_Dhl = 0.
- First cycle after reset deasserts: imemreq_val = 1 with address RESET_VECTOR.
- Response to D latency: a response accepted in cycle n is visible on inst_val_Dhl in cycle n+1 (registered, no bypass).
- With 1-cycle memory and DEPTH = 2, sustained throughput is one instruction per cycle while inst_rdy_Dhl stays high.
- A redirect in cycle n:
  - a request at pc_redirect_addr may issue in cycle n;
  - inst_val_Dhl = 0 in cycle n+1 unless a new-epoch response arrived in cycle n.
- Reset asserted mid-operation clears all state immediately (asynchronously). In-flight responses that return later are ignored.

## Test plan

- Reset release, 1-cycle memory, inst_rdy_Dhl = 1:
  - requests go to 0x80000, 0x80004, 0x80008 on consecutive cycles;
  - inst_val_Dhl rises 2 cycles after reset release, with pc_Dhl = 0x80000, then one instruction per cycle;
  - pc_plus4_Dhl = pc_Dhl + 4.
- Hold inst_rdy_Dhl = 0 for 5 cycles:
  - imemreq_val drops once 2 entries are buffered or outstanding;
  - on release, instructions 0x80000 and 0x80004 drain in order, none lost or duplicated.
- 3-cycle memory latency with two outstanding requests, redirect to 0x80100 issued one cycle after them:
  - both stale responses are dropped;
  - the first instruction delivered to D has pc_Dhl = 0x80100.
- Redirect to 0x80200 in the same cycle as a dequeue and a stale response arrival:
  - buffer is empty next cycle;
  - request address that cycle = 0x80200;
  - pc_Fhl advances to 0x80204.
- Assert reset while 2 requests are in flight, deassert it, then return 2 responses:
  - both responses are ignored;
  - the first delivered pc_Dhl = 0x80000.
- pc_redirect_addr = 0xFFFFFFFC:
  - the next request address wraps to 0x00000000.

Source files
------------

// File: rtl/parc_core_fetch_queue.sv
// PARCv2 fetch front end: owns the fetch PC, tracks in-flight imem requests
// with an epoch tag and buffers surviving instructions for Decode.
module parc_core_fetch_queue #(
  parameter int unsigned DEPTH        = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h00080000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_redirect_val,
  input  logic [31:0] pc_redirect_addr,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_msg_addr,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_msg_data,
  output logic        inst_val_Dhl,
  input  logic        inst_rdy_Dhl,
  output logic [31:0] inst_Dhl,
  output logic [31:0] pc_Dhl,
  output logic [31:0] pc_plus4_Dhl
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [31:0] pc_Fhl;
  logic        epoch;

  logic [31:0] fl_addr  [DEPTH];
  logic        fl_epoch [DEPTH];
  ptr_t        fl_wr;
  ptr_t        fl_rd;
  cnt_t        fl_cnt;

  logic [31:0] bf_inst [DEPTH];
  logic [31:0] bf_pc   [DEPTH];
  ptr_t        bf_wr;
  ptr_t        bf_rd;
  cnt_t        bf_cnt;

  logic        deq;
  logic        epoch_n;
  logic        fire;
  logic        resp;
  logic        keep;
  ptr_t        bf_widx;
  cnt_t        buf_used;
  cnt_t        used;

  assign deq     = inst_val_Dhl & inst_rdy_Dhl;
  assign epoch_n = epoch ^ pc_redirect_val;

  // A redirect flushes the buffer, so its entries stop holding credits.
  always_comb begin
    buf_used = pc_redirect_val ? '0 : bf_cnt - cnt_t'(deq);
    used     = fl_cnt + buf_used;
  end

  assign imemreq_val      = reset & (used < cnt_t'(DEPTH));
  assign imemreq_msg_addr = pc_redirect_val ? pc_redirect_addr : pc_Fhl;
  assign fire             = imemreq_val & imemreq_rdy;

  assign resp    = imemresp_val & (fl_cnt != '0);
  assign keep    = resp & (fl_epoch[fl_rd] == epoch_n);
  assign bf_widx = pc_redirect_val ? '0 : bf_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_Fhl <= RESET_VECTOR;
      epoch  <= 1'b0;
    end else begin
      epoch <= epoch_n;
      if (fire)
        pc_Fhl <= imemreq_msg_addr + 32'd4;
      else if (pc_redirect_val)
        pc_Fhl <= pc_redirect_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fl_wr  <= '0;
      fl_rd  <= '0;
      fl_cnt <= '0;
    end else begin
      fl_wr  <= fl_wr + ptr_t'(fire);
      fl_rd  <= fl_rd + ptr_t'(resp);
      fl_cnt <= fl_cnt + cnt_t'(fire) - cnt_t'(resp);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bf_wr  <= '0;
      bf_rd  <= '0;
      bf_cnt <= '0;
    end else if (pc_redirect_val) begin
      bf_wr  <= ptr_t'(keep);
      bf_rd  <= '0;
      bf_cnt <= cnt_t'(keep);
    end else begin
      bf_wr  <= bf_wr + ptr_t'(keep);
      bf_rd  <= bf_rd + ptr_t'(deq);
      bf_cnt <= bf_cnt + cnt_t'(keep) - cnt_t'(deq);
    end
  end

  // Storage only; validity is carried by the counters above.
  always_ff @(posedge clk) begin
    if (fire) begin
      fl_addr[fl_wr]  <= imemreq_msg_addr;
      fl_epoch[fl_wr] <= epoch_n;
    end
    if (keep) begin
      bf_inst[bf_widx] <= imemresp_msg_data;
      bf_pc[bf_widx]   <= fl_addr[fl_rd];
    end
  end

  assign inst_val_Dhl = bf_cnt != '0;
  assign inst_Dhl     = inst_val_Dhl ? bf_inst[bf_rd] : '0;
  assign pc_Dhl       = inst_val_Dhl ? bf_pc[bf_rd] : '0;
  assign pc_plus4_Dhl = inst_val_Dhl ? bf_pc[bf_rd] + 32'd4 : '0;

endmodule

// File: tb/tb_parc_core_fetch_queue.sv
// Bench for parc_core_fetch_queue: directed scenarios, variable-latency
// in-order memory model, scoreboard monitor on requests and dequeues.
module tb_parc_core_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_redirect_val = 1'b0;
  logic [31:0] pc_redirect_addr = '0;
  logic        imemreq_val;
  logic        imemreq_rdy = 1'b1;
  logic [31:0] imemreq_msg_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_msg_data;
  logic        inst_val_Dhl;
  logic        inst_rdy_Dhl = 1'b0;
  logic [31:0] inst_Dhl;
  logic [31:0] pc_Dhl;
  logic [31:0] pc_plus4_Dhl;

  parc_core_fetch_queue dut (
    .clk               (clk),
    .reset             (reset),
    .pc_redirect_val   (pc_redirect_val),
    .pc_redirect_addr  (pc_redirect_addr),
    .imemreq_val       (imemreq_val),
    .imemreq_rdy       (imemreq_rdy),
    .imemreq_msg_addr  (imemreq_msg_addr),
    .imemresp_val      (imemresp_val),
    .imemresp_msg_data (imemresp_msg_data),
    .inst_val_Dhl      (inst_val_Dhl),
    .inst_rdy_Dhl      (inst_rdy_Dhl),
    .inst_Dhl          (inst_Dhl),
    .pc_Dhl            (pc_Dhl),
    .pc_plus4_Dhl      (pc_plus4_Dhl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mem_t;

  mem_t        mq[$];
  mem_t        mnew;
  int          lat = 1;
  int          tcyc = 0;
  logic [31:0] exp_pc[$];
  logic [31:0] exp_req[$];
  logic [31:0] mon_e;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) tcyc <= tcyc + 1;

  // In-order memory: response for a request fired in cycle k returns in k+lat.
  always @(negedge clk) begin
    imemresp_val = 1'b0;
    imemresp_msg_data = '0;
    if (mq.size() != 0 && mq[0].due <= tcyc) begin
      imemresp_val = 1'b1;
      imemresp_msg_data = mq[0].data;
      void'(mq.pop_front());
    end
    #1;
    if (imemreq_val && imemreq_rdy) begin
      mnew.data = memf(imemreq_msg_addr);
      mnew.due  = tcyc + lat;
      mq.push_back(mnew);
    end
  end

  // Monitor
  always @(negedge clk) begin
    #2;
    if (imemreq_val && imemreq_rdy && exp_req.size() != 0)
      chk("req_addr", imemreq_msg_addr, exp_req.pop_front());
    if (inst_val_Dhl && inst_rdy_Dhl) begin
      if (exp_pc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_deq: got pc %h, required no dequeue", pc_Dhl);
      end else begin
        mon_e = exp_pc.pop_front();
        chk("deq_pc", pc_Dhl, mon_e);
        chk("deq_inst", inst_Dhl, memf(mon_e));
        chk("deq_pc_plus4", pc_plus4_Dhl, mon_e + 32'd4);
      end
    end
  end

  task automatic rst_rel(input int l);
    @(negedge clk);
    reset = 1'b0;
    inst_rdy_Dhl = 1'b0;
    pc_redirect_val = 1'b0;
    imemreq_rdy = 1'b1;
    lat = l;
    #1;
    chk("rst_reqval", 32'(imemreq_val), 32'd0);
    chk("rst_instval", 32'(inst_val_Dhl), 32'd0);
    chk("rst_addr", imemreq_msg_addr, 32'h00080000);
    chk("rst_inst", inst_Dhl, 32'd0);
    chk("rst_pc", pc_Dhl, 32'd0);
    chk("rst_pc4", pc_plus4_Dhl, 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_pc.size() != 0 || exp_req.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_pc.size() != 0 || exp_req.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pcs and %0d reqs pending, required 0",
               nm, exp_pc.size(), exp_req.size());
      exp_pc.delete();
      exp_req.delete();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // A: startup with 1-cycle memory
    rst_rel(1);
    exp_req = '{32'h80000, 32'h80004, 32'h80008};
    exp_pc  = '{32'h80000, 32'h80004, 32'h80008,
                32'h8000C, 32'h80010, 32'h80014};
    inst_rdy_Dhl = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 8) inst_rdy_Dhl = 1'b0;
      #1;
      if (c == 0) chk("A_reqval0", 32'(imemreq_val), 32'd1);
      if (c < 8) chk("A_instval", 32'(inst_val_Dhl), 32'(c >= 2));
    end
    drain("A");

    // B: D stalls for 5 cycles
    rst_rel(1);
    exp_req = '{32'h80000, 32'h80004, 32'h80008};
    exp_pc  = '{32'h80000, 32'h80004, 32'h80008};
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) inst_rdy_Dhl = 1'b1;
      if (c == 8) inst_rdy_Dhl = 1'b0;
      #1;
      if (c < 5) chk("B_reqval", 32'(imemreq_val), 32'(c < 2));
      if (c == 4) chk("B_head_pc", pc_Dhl, 32'h80000);
    end
    drain("B");

    // C: 3-cycle memory, redirect while two requests outstanding
    rst_rel(3);
    exp_req = '{32'h80000, 32'h80004, 32'h80100, 32'h80104};
    exp_pc  = '{32'h80100, 32'h80104};
    inst_rdy_Dhl = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) begin
        pc_redirect_val = 1'b1;
        pc_redirect_addr = 32'h80100;
      end
      if (c == 3) pc_redirect_val = 1'b0;
      if (c == 10) inst_rdy_Dhl = 1'b0;
      #1;
      if (c == 2) chk("C_reqval_full", 32'(imemreq_val), 32'd0);
      if (c >= 3 && c <= 7) chk("C_instval", 32'(inst_val_Dhl), 32'd0);
    end
    drain("C");

    // D: redirect with same-cycle dequeue and stale response
    rst_rel(1);
    exp_req = '{32'h80000, 32'h80004, 32'h80008,
                32'h8000C, 32'h80200, 32'h80204};
    exp_pc  = '{32'h80000, 32'h80004, 32'h80008, 32'h80200, 32'h80204};
    inst_rdy_Dhl = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 4) begin
        pc_redirect_val = 1'b1;
        pc_redirect_addr = 32'h80200;
      end
      if (c == 5) pc_redirect_val = 1'b0;
      if (c == 8) inst_rdy_Dhl = 1'b0;
      #1;
      if (c == 4) begin
        chk("D_deq", 32'(inst_val_Dhl & inst_rdy_Dhl), 32'd1);
        chk("D_reqval", 32'(imemreq_val), 32'd1);
      end
      if (c == 5) begin
        chk("D_empty", 32'(inst_val_Dhl), 32'd0);
        chk("D_reqval_next", 32'(imemreq_val), 32'd1);
      end
    end
    drain("D");

    // E: reset while two requests in flight; stale responses return later
    rst_rel(3);
    exp_req = '{32'h80000, 32'h80004, 32'h80000, 32'h80004};
    exp_pc  = '{32'h80000, 32'h80004};
    inst_rdy_Dhl = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) reset = 1'b0;
      if (c == 3) begin
        reset = 1'b1;
        imemreq_rdy = 1'b0;
      end
      if (c == 5) imemreq_rdy = 1'b1;
      if (c == 12) inst_rdy_Dhl = 1'b0;
      #1;
      if (c == 2) chk("E_async_addr", imemreq_msg_addr, 32'h80000);
      if (c >= 3 && c <= 8) chk("E_instval", 32'(inst_val_Dhl), 32'd0);
    end
    drain("E");

    // F: PC wrap
    rst_rel(1);
    exp_req = '{32'hFFFFFFFC, 32'h00000000};
    exp_pc  = '{32'hFFFFFFFC, 32'h00000000};
    inst_rdy_Dhl = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        pc_redirect_val = 1'b1;
        pc_redirect_addr = 32'hFFFFFFFC;
      end
      if (c == 1) pc_redirect_val = 1'b0;
      if (c == 4) inst_rdy_Dhl = 1'b0;
      #1;
      if (c == 1) chk("F_wrap_addr", imemreq_msg_addr, 32'h00000000);
    end
    drain("F");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
